// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// ad_ip_jesd204_tpl_adc_pack
//
// Packs the enabled channels of the TPL ADC formatted sample bus into
// full-width words for the DMA/FIFO write side. Samples are ordered
// time-major (all enabled channels at t=0, then t=1, ...) and accumulated
// until a full word of TOTAL samples is available. The ADC stream never
// stalls, so there is no backpressure.
//
// Optional build macro: AD_IP_JESD204_TPL_ADC_PACK_FLUSH_EN
//   When defined, a realign event with samples buffered emits those samples
//   once as a zero-padded word flagged by packed_partial. When undefined,
//   partial words are dropped and packed_partial is tied low.
//
// Ports:
//   clk            core (link) clock
//   reset          synchronous, active-high reset
//   adc_valid      per-channel valid; bit 0 qualifies the beat
//   adc_data       channel c, time t at [(c*DATA_PATH_WIDTH+t)*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   adc_enable     channel enable mask, quasi-static
//   adc_sync       one-cycle realign pulse
//   packed_valid   one-cycle strobe, packed word available
//   packed_data    packed word; sample k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   packed_sync    marks the first word after reset or realign
//   packed_partial marks a zero-padded flush word (flush build only)

module ad_ip_jesd204_tpl_adc_pack #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int SAMPLE_WIDTH    = 16
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [NUM_CHANNELS-1:0]                               adc_valid,
  input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0]  adc_data,
  input  logic [NUM_CHANNELS-1:0]                               adc_enable,
  input  logic                                                  adc_sync,
  output logic                                                  packed_valid,
  output logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0]  packed_data,
  output logic                                                  packed_sync,
  output logic                                                  packed_partial
);

  localparam int TOTAL      = NUM_CHANNELS * DATA_PATH_WIDTH;
  localparam int DATA_WIDTH = TOTAL * SAMPLE_WIDTH;
  localparam int FILL_W     = $clog2(2 * TOTAL);
  localparam int CH_W       = $clog2(NUM_CHANNELS + 1);

  function automatic logic [CH_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] m);
    logic [CH_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt = cnt + CH_W'(m[i]);
    end
    return cnt;
  endfunction

  // Gathers enabled channels time-major into the low slots; unused slots are zero.
  function automatic logic [DATA_WIDTH-1:0] compact(input logic [DATA_WIDTH-1:0]   d,
                                                    input logic [NUM_CHANNELS-1:0] m);
    logic [DATA_WIDTH-1:0]          r;
    logic signed [SAMPLE_WIDTH-1:0] smp;
    int                             k;
    r = '0;
    k = 0;
    for (int t = 0; t < DATA_PATH_WIDTH; t++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (m[c]) begin
          smp = d[(c*DATA_PATH_WIDTH+t)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          r[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = smp;
          k++;
        end
      end
    end
    return r;
  endfunction

  // All valid bits are equal; only bit 0 carries meaning.
  logic unused_valid_bits;
  assign unused_valid_bits = ^adc_valid[NUM_CHANNELS-1:1];

  logic [NUM_CHANNELS-1:0] enable_q;
  logic                    realign;
  logic [CH_W-1:0]         ch_cnt;
  logic [FILL_W-1:0]       n_in;

  assign realign = adc_sync | (adc_enable != enable_q);
  assign ch_cnt  = popcount(adc_enable);
  assign n_in    = FILL_W'(ch_cnt) * FILL_W'(DATA_PATH_WIDTH);

  // ---- stage 1: compaction ----
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [FILL_W-1:0]     cnt_p1;

  always_ff @(posedge clk) begin
    // Tracked through reset so the first cycle after release is not a realign.
    enable_q <= adc_enable;
    data_p1  <= compact(adc_data, adc_enable);
    cnt_p1   <= n_in;
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= adc_valid[0] & (ch_cnt != '0) & ~realign;
    end
  end

  // ---- stage 2: accumulate and emit ----
  logic [2*DATA_WIDTH-1:0] buf_p2;
  logic [FILL_W-1:0]       fill_p2;
  logic                    first_p2;
  logic [FILL_W-1:0]       fill_sum;
  logic                    word_done;
  logic [2*DATA_WIDTH-1:0] merged;

  assign fill_sum  = fill_p2 + cnt_p1;
  assign word_done = vld_p1 & (fill_sum >= FILL_W'(TOTAL));
  // Slots at and above fill are always zero, so OR-ing appends the new samples.
  assign merged    = buf_p2 | ({{DATA_WIDTH{1'b0}}, data_p1} << (fill_p2 * SAMPLE_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      packed_valid <= 1'b0;
      packed_data  <= '0;
      packed_sync  <= 1'b0;
      fill_p2      <= '0;
      first_p2     <= 1'b1;
      // The buffer must be cleared too: the append relies on zeros above fill.
      buf_p2       <= '0;
    end else if (realign) begin
      packed_valid <= 1'b0;
      packed_sync  <= 1'b0;
`ifdef AD_IP_JESD204_TPL_ADC_PACK_FLUSH_EN
      if (fill_p2 != '0) begin
        packed_valid <= 1'b1;
        packed_data  <= buf_p2[DATA_WIDTH-1:0];
      end
`endif
      fill_p2  <= '0;
      buf_p2   <= '0;
      first_p2 <= 1'b1;
    end else begin
      packed_valid <= word_done;
      packed_sync  <= word_done & first_p2;
      if (vld_p1) begin
        if (word_done) begin
          packed_data <= merged[DATA_WIDTH-1:0];
          buf_p2      <= merged >> DATA_WIDTH;
          fill_p2     <= fill_sum - FILL_W'(TOTAL);
          first_p2    <= 1'b0;
        end else begin
          buf_p2  <= merged;
          fill_p2 <= fill_sum;
        end
      end
    end
  end

`ifdef AD_IP_JESD204_TPL_ADC_PACK_FLUSH_EN
  logic partial_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      partial_p2 <= 1'b0;
    end else begin
      partial_p2 <= realign & (fill_p2 != '0);
    end
  end

  assign packed_partial = partial_p2;
`else
  assign packed_partial = 1'b0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Testbench for ad_ip_jesd204_tpl_adc_pack (default parameters: 4 channels,
// 2 samples per channel per beat, 16-bit samples). A sample-queue reference
// model predicts every packed word and the edge at which it appears.

module tb_ad_ip_jesd204_tpl_adc_pack;

  localparam int NC  = 4;
  localparam int DPW = 2;
  localparam int SW  = 16;
  localparam int TOT = NC * DPW;
  localparam int DW  = TOT * SW;

`ifdef AD_IP_JESD204_TPL_ADC_PACK_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [NC-1:0] adc_valid;
  logic [DW-1:0] adc_data;
  logic [NC-1:0] adc_enable;
  logic          adc_sync;
  logic          packed_valid;
  logic [DW-1:0] packed_data;
  logic          packed_sync;
  logic          packed_partial;

  ad_ip_jesd204_tpl_adc_pack #(
    .NUM_CHANNELS    (NC),
    .DATA_PATH_WIDTH (DPW),
    .SAMPLE_WIDTH    (SW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .adc_enable     (adc_enable),
    .adc_sync       (adc_sync),
    .packed_valid   (packed_valid),
    .packed_data    (packed_data),
    .packed_sync    (packed_sync),
    .packed_partial (packed_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            edge_n;
    logic [DW-1:0] data;
    logic          sync;
    logic          partial;
  } exp_t;

  exp_t          expq[$];
  logic [SW-1:0] smpq[$];
  logic          first_m;
  logic [NC-1:0] prev_en;
  int            kcnt;
  int            checks;
  int            errors;
  logic [DW+2:0] got;
  logic [DW+2:0] want;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, advance the reference model, sample outputs #1
  // after the edge. Returns {valid,sync,partial,data} observed and predicted;
  // data is masked out when no word is expected (except under reset).
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [NC-1:0] en,
                     input logic sy, input logic rst,
                     output logic [DW+2:0] o_got, output logic [DW+2:0] o_want);
    int            k;
    logic          ev;
    logic [DW-1:0] w;
    exp_t          e;
    reset      = rst;
    adc_valid  = {NC{v}};
    adc_data   = d;
    adc_enable = en;
    adc_sync   = sy;
    k  = kcnt + 1;
    ev = sy || (en != prev_en);
    if (rst) begin
      while (expq.size() > 0 && expq[0].edge_n <= k) void'(expq.pop_front());
      smpq.delete();
      first_m = 1'b1;
    end else if (ev) begin
      while (expq.size() > 0 && expq[0].edge_n <= k) void'(expq.pop_front());
      if (FLUSH && smpq.size() > 0) begin
        w = '0;
        for (int i = 0; i < TOT && smpq.size() > 0; i++) w[i*SW +: SW] = smpq.pop_front();
        e.edge_n = k; e.data = w; e.sync = 1'b0; e.partial = 1'b1;
        expq.push_back(e);
      end
      smpq.delete();
      first_m = 1'b1;
    end else if (v && en != '0) begin
      for (int t = 0; t < DPW; t++)
        for (int c = 0; c < NC; c++)
          if (en[c]) smpq.push_back(d[(c*DPW+t)*SW +: SW]);
      if (smpq.size() >= TOT) begin
        for (int i = 0; i < TOT; i++) w[i*SW +: SW] = smpq.pop_front();
        e.edge_n = k + 1; e.data = w; e.sync = first_m; e.partial = 1'b0;
        expq.push_back(e);
        first_m = 1'b0;
      end
    end
    prev_en = en;
    @(posedge clk);
    kcnt++;
    #1;
    o_got = {packed_valid, packed_sync, packed_partial, packed_data};
    if (!rst && expq.size() > 0 && expq[0].edge_n == kcnt) begin
      e = expq.pop_front();
      o_want = {1'b1, e.sync, e.partial, e.data};
    end else begin
      o_want = '0;
      if (!rst) o_got[DW-1:0] = '0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, '0, 4'hf, 1'b0, 1'b1, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset edge=%0d got %h want %h", kcnt, got, want);
      end
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] pat;
    logic [DW-1:0] lit;
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < DPW; t++) pat[(c*DPW+t)*SW +: SW] = {8'(c), 8'(t)};
    lit = {16'h0301, 16'h0201, 16'h0101, 16'h0001, 16'h0300, 16'h0200, 16'h0100, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      cyc(i < 6, (i == 0) ? pat : rand_beat(), 4'hf, 1'b0, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL full_word edge=%0d got %h want %h", kcnt, got, want);
      end
      if (i == 1) begin
        checks++;
        if (got[DW+2:DW+1] !== 2'b11 || got[DW-1:0] !== lit) begin
          errors++;
          $display("FAIL full_order got %h want valid,sync=1 data %h", got, lit);
        end
      end
    end
  endtask

  task automatic test_sparse();
    for (int i = 0; i < 12; i++) begin
      cyc(i >= 1 && i < 9, rand_beat(), 4'b0101, 1'b0, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sparse_0101 edge=%0d got %h want %h", kcnt, got, want);
      end
    end
  endtask

  task automatic test_odd();
    int words;
    words = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(i >= 1 && i < 5, rand_beat(), 4'b0111, 1'b0, 1'b0, got, want);
      words += int'(got[DW+2]);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL odd_0111 edge=%0d got %h want %h", kcnt, got, want);
      end
    end
    checks++;
    if (words !== 3) begin
      errors++;
      $display("FAIL odd_word_count got %0d want 3", words);
    end
  endtask

  task automatic test_switch();
    logic [NC-1:0] en;
    for (int i = 0; i < 10; i++) begin
      en = (i < 4) ? 4'b0011 : 4'b1111;
      cyc(i == 1 || i == 6, rand_beat(), en, 1'b0, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_switch edge=%0d got %h want %h", kcnt, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int words;
    words = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(i == 1 || (i >= 5 && i < 9), rand_beat(), 4'b0111, 1'b0, i == 3, got, want);
      if (i >= 5) words += int'(got[DW+2]);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid edge=%0d got %h want %h", kcnt, got, want);
      end
    end
    checks++;
    if (words !== 3) begin
      errors++;
      $display("FAIL reset_mid_word_count got %0d want 3", words);
    end
  endtask

  task automatic test_gaps_sync();
    for (int i = 0; i < 40; i++) begin
      cyc(i > 0 && i < 37 && (i % 3 == 0), rand_beat(), 4'b0101, i == 18, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL gaps_sync edge=%0d got %h want %h", kcnt, got, want);
      end
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] en;
    for (int r = 0; r < 6; r++) begin
      en = NC'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        cyc(i > 0 && i < 13 && ($urandom % 4 != 0), rand_beat(), en, 1'b0, 1'b0, got, want);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random en=%b edge=%0d got %h want %h", en, kcnt, got, want);
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    kcnt       = 0;
    first_m    = 1'b1;
    prev_en    = 4'hf;
    reset      = 1'b1;
    adc_valid  = '0;
    adc_data   = '0;
    adc_enable = 4'hf;
    adc_sync   = 1'b0;
    test_reset();
    test_full();
    test_sparse();
    test_odd();
    test_switch();
    test_reset_mid();
    test_gaps_sync();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
